// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle instruction sequencer for a small CPU.
// Walks each instruction through FETCH, DECODE, EXEC or MEM, and WB over a
// single shared memory port, with a timeout that parks the sequencer in FAULT.
//
// Ports:
//   clk, reset_n          - system clock, synchronous active-low reset
//   run                   - enable instruction sequencing
//   opcode, dec_*         - instruction opcode and decoder controls, captured in DECODE
//   mem_ready             - shared memory acknowledge (only looked at in FETCH/MEM)
//   mem_req/mem_we/mem_sel - memory request, write enable, select (0 instr, 1 data)
//   ir_load, rf_we, nz_we, pc_we - single-cycle strobes
//   state, busy, fault, instr_count - status
module cpu_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  input  logic [4:0]  opcode,
  input  logic        dec_RegWrite,
  input  logic        dec_MemWrite,
  input  logic        dec_mem_sel,
  input  logic        dec_NZ,
  input  logic        dec_pc_enable,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel,
  output logic        ir_load,
  output logic        rf_we,
  output logic        nz_we,
  output logic        pc_we,
  output logic [2:0]  state,
  output logic        busy,
  output logic        fault,
  output logic [15:0] instr_count
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StFault  = 3'd6
  } state_e;

  localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [15:0] instr_count_q, instr_count_d;
  logic [4:0]  opcode_q, opcode_d;
  logic        reg_write_q, reg_write_d;
  logic        mem_write_q, mem_write_d;
  logic        mem_sel_q, mem_sel_d;
  logic        nz_q, nz_d;
  logic        pc_enable_q, pc_enable_d;
  logic        timed_out;

  // Last permitted wait cycle with still no acknowledge.
  assign timed_out = (wait_q == WaitLast) && !mem_ready;

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    instr_count_d = instr_count_q;
    opcode_d      = opcode_q;
    reg_write_d   = reg_write_q;
    mem_write_d   = mem_write_q;
    mem_sel_d     = mem_sel_q;
    nz_d          = nz_q;
    pc_enable_d   = pc_enable_q;
    case (state_q)
      StIdle: begin
        if (run) begin
          state_d = StFetch;
          wait_d  = '0;
        end
      end
      StFetch: begin
        if (mem_ready) begin
          state_d = StDecode;
        end else begin
          wait_d = wait_q + 8'd1;
          if (timed_out) state_d = StFault;
        end
      end
      StDecode: begin
        // Snapshot the decode so later input changes cannot disturb this instruction.
        opcode_d    = opcode;
        reg_write_d = dec_RegWrite;
        mem_write_d = dec_MemWrite;
        mem_sel_d   = dec_mem_sel;
        nz_d        = dec_NZ;
        pc_enable_d = dec_pc_enable;
        if (dec_mem_sel || dec_MemWrite) begin
          state_d = StMem;
          wait_d  = '0;
        end else begin
          state_d = StExec;
        end
      end
      StExec: state_d = StWb;
      StMem: begin
        if (mem_ready) begin
          state_d = StWb;
        end else begin
          wait_d = wait_q + 8'd1;
          if (timed_out) state_d = StFault;
        end
      end
      StWb: begin
        instr_count_d = instr_count_q + 16'd1;
        if (run) begin
          state_d = StFetch;
          wait_d  = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      wait_q        <= '0;
      instr_count_q <= '0;
      opcode_q      <= '0;
      reg_write_q   <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_sel_q     <= 1'b0;
      nz_q          <= 1'b0;
      pc_enable_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      instr_count_q <= instr_count_d;
      opcode_q      <= opcode_d;
      reg_write_q   <= reg_write_d;
      mem_write_q   <= mem_write_d;
      mem_sel_q     <= mem_sel_d;
      nz_q          <= nz_d;
      pc_enable_q   <= pc_enable_d;
    end
  end

  // ir_load follows mem_ready combinationally so the IR captures in the ack cycle.
  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    mem_sel = 1'b0;
    ir_load = 1'b0;
    rf_we   = 1'b0;
    nz_we   = 1'b0;
    pc_we   = 1'b0;
    case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        ir_load = mem_ready;
      end
      StMem: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = mem_write_q;
      end
      StWb: begin
        rf_we = reg_write_q;
        nz_we = nz_q;
        pc_we = pc_enable_q;
      end
      default: ;
    endcase
  end

  assign state       = state_q;
  assign busy        = (state_q != StIdle) && (state_q != StFault);
  assign fault       = (state_q == StFault);
  assign instr_count = instr_count_q;

  // Captured opcode and data-select are held for the datapath but not used here.
  logic unused_latched;
  assign unused_latched = ^{opcode_q, mem_sel_q};

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

  localparam int unsigned T = 16;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DEC = 3'd2, S_EXEC = 3'd3,
                         S_MEM = 3'd4, S_WB = 3'd5, S_FAULT = 3'd6;
  // Strobe bundle: {mem_req, mem_we, mem_sel, ir_load, rf_we, nz_we, pc_we}
  localparam logic [6:0] O_NONE = 7'b000_0000, O_FETCH = 7'b100_0000, O_IRL = 7'b100_1000,
                         O_MEMR = 7'b101_0000, O_MEMW = 7'b111_0000, O_RF = 7'b000_0100;
  // Decoder bundle: {RegWrite, MemWrite, mem_sel, NZ, pc_enable}
  localparam logic [4:0] D_ADD = 5'b10000, D_MVI = 5'b10100, D_JUNK = 5'b01111;
  localparam logic [4:0] OP_ADD = 5'b00001, OP_MVI = 5'b10000;

  logic        clk = 1'b0;
  logic        reset_n, run, mem_ready;
  logic [4:0]  opcode;
  logic        dec_RegWrite, dec_MemWrite, dec_mem_sel, dec_NZ, dec_pc_enable;
  logic        mem_req, mem_we, mem_sel, ir_load, rf_we, nz_we, pc_we;
  logic [2:0]  state;
  logic        busy, fault;
  logic [15:0] instr_count;

  always #5 clk = ~clk;

  cpu_sequencer #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .opcode(opcode),
    .dec_RegWrite(dec_RegWrite), .dec_MemWrite(dec_MemWrite), .dec_mem_sel(dec_mem_sel),
    .dec_NZ(dec_NZ), .dec_pc_enable(dec_pc_enable), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .ir_load(ir_load),
    .rf_we(rf_we), .nz_we(nz_we), .pc_we(pc_we), .state(state), .busy(busy),
    .fault(fault), .instr_count(instr_count)
  );

  typedef struct {
    logic        rst_n;
    logic        run;
    logic        rdy;
    logic [4:0]  opc;
    logic [4:0]  dec;
    logic [2:0]  st;
    logic [6:0]  outs;
    logic [15:0] cnt;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] mcnt;  // reference instruction count

  function automatic vec_t mk(input logic rst_n, input logic r, input logic rdy,
                              input logic [4:0] opc, input logic [4:0] dec,
                              input logic [2:0] st, input logic [6:0] outs,
                              input logic [15:0] cnt);
    vec_t v;
    v.rst_n = rst_n; v.run = r; v.rdy = rdy; v.opc = opc; v.dec = dec;
    v.st = st; v.outs = outs; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input string field, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s %s: got %0h expected %0h", name, field, act, exp);
    end
  endtask

  // Called just after a falling edge: drive, check, then advance one clock.
  task automatic apply(input string name, input vec_t v);
    reset_n   = v.rst_n;
    run       = v.run;
    mem_ready = v.rdy;
    opcode    = v.opc;
    {dec_RegWrite, dec_MemWrite, dec_mem_sel, dec_NZ, dec_pc_enable} = v.dec;
    #1;
    chk(name, "state", 32'(state), 32'(v.st));
    chk(name, "strobes", 32'({mem_req, mem_we, mem_sel, ir_load, rf_we, nz_we, pc_we}),
        32'(v.outs));
    chk(name, "busy", 32'(busy), 32'(v.st >= S_FETCH && v.st <= S_WB));
    chk(name, "fault", 32'(fault), 32'(v.st == S_FAULT));
    chk(name, "instr_count", 32'(instr_count), 32'(v.cnt));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cyc(input string name, input logic rst_n, input logic r, input logic rdy,
                     input logic [4:0] opc, input logic [4:0] dec, input logic [2:0] st,
                     input logic [6:0] outs);
    apply(name, mk(rst_n, r, rdy, opc, dec, st, outs, mcnt));
  endtask

  function automatic logic [4:0] junk5();
    return 5'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  // Instruction-level reference: each instruction expands to its cycle trace.
  task automatic rand_phase(input int n);
    logic idle;
    idle = 1'b1;
    for (int i = 0; i < n; i++) begin
      logic [4:0] dec;
      logic [4:0] opc;
      int         fw, mw, k;
      logic       cont, is_mem;
      dec    = junk5();
      opc    = junk5();
      fw     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, T - 1))
                                           : int'($urandom_range(0, 2));
      mw     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, T - 1))
                                           : int'($urandom_range(0, 2));
      cont   = ($urandom_range(0, 3) != 0);
      is_mem = dec[3] | dec[2];
      if (idle) begin
        k = int'($urandom_range(0, 2));
        for (int j = 0; j < k; j++) cyc("rnd_idle", 1'b1, 1'b0, rbit(), junk5(), junk5(),
                                        S_IDLE, O_NONE);
        cyc("rnd_go", 1'b1, 1'b1, rbit(), junk5(), junk5(), S_IDLE, O_NONE);
      end
      for (int j = 0; j < fw; j++)
        cyc("rnd_fwait", 1'b1, rbit(), 1'b0, junk5(), junk5(), S_FETCH, O_FETCH);
      cyc("rnd_fetch", 1'b1, rbit(), 1'b1, junk5(), junk5(), S_FETCH, O_IRL);
      cyc("rnd_dec", 1'b1, rbit(), rbit(), opc, dec, S_DEC, O_NONE);
      if (is_mem) begin
        for (int j = 0; j < mw; j++)
          cyc("rnd_mwait", 1'b1, rbit(), 1'b0, junk5(), junk5(), S_MEM,
              {1'b1, dec[3], 1'b1, 4'b0000});
        cyc("rnd_mem", 1'b1, rbit(), 1'b1, junk5(), junk5(), S_MEM,
            {1'b1, dec[3], 1'b1, 4'b0000});
      end else begin
        cyc("rnd_exec", 1'b1, rbit(), rbit(), junk5(), junk5(), S_EXEC, O_NONE);
      end
      cyc("rnd_wb", 1'b1, cont, rbit(), junk5(), junk5(), S_WB,
          {4'b0000, dec[4], dec[1], dec[0]});
      mcnt = mcnt + 16'd1;
      idle = !cont;
    end
    if (!idle) begin
      // Last WB chose FETCH; finish that fetch so the bench ends in a known spot.
      cyc("rnd_tail", 1'b1, 1'b0, 1'b0, junk5(), junk5(), S_FETCH, O_FETCH);
    end
  endtask

  vec_t tbl[18];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Steady add loop, then an mvi with three MEM wait cycles. Junk decode values
    // outside DECODE must not leak into WB.
    tbl[0]  = mk(1, 0, 1, OP_ADD, D_JUNK, S_IDLE,  O_NONE, 16'd0);
    tbl[1]  = mk(1, 1, 0, OP_ADD, D_JUNK, S_IDLE,  O_NONE, 16'd0);
    tbl[2]  = mk(1, 1, 1, OP_ADD, D_JUNK, S_FETCH, O_IRL,  16'd0);
    tbl[3]  = mk(1, 1, 1, OP_ADD, D_ADD,  S_DEC,   O_NONE, 16'd0);
    tbl[4]  = mk(1, 1, 1, OP_ADD, D_JUNK, S_EXEC,  O_NONE, 16'd0);
    tbl[5]  = mk(1, 1, 1, OP_ADD, D_JUNK, S_WB,    O_RF,   16'd0);
    tbl[6]  = mk(1, 1, 1, OP_ADD, D_JUNK, S_FETCH, O_IRL,  16'd1);
    tbl[7]  = mk(1, 1, 1, OP_ADD, D_ADD,  S_DEC,   O_NONE, 16'd1);
    tbl[8]  = mk(1, 1, 1, OP_ADD, D_JUNK, S_EXEC,  O_NONE, 16'd1);
    tbl[9]  = mk(1, 1, 1, OP_ADD, D_JUNK, S_WB,    O_RF,   16'd1);
    tbl[10] = mk(1, 1, 1, OP_ADD, D_JUNK, S_FETCH, O_IRL,  16'd2);
    tbl[11] = mk(1, 1, 1, OP_MVI, D_MVI,  S_DEC,   O_NONE, 16'd2);
    tbl[12] = mk(1, 1, 0, OP_MVI, D_JUNK, S_MEM,   O_MEMR, 16'd2);
    tbl[13] = mk(1, 1, 0, OP_MVI, D_JUNK, S_MEM,   O_MEMR, 16'd2);
    tbl[14] = mk(1, 1, 0, OP_MVI, D_JUNK, S_MEM,   O_MEMR, 16'd2);
    tbl[15] = mk(1, 1, 1, OP_MVI, D_JUNK, S_MEM,   O_MEMR, 16'd2);
    tbl[16] = mk(1, 0, 1, OP_MVI, D_JUNK, S_WB,    O_RF,   16'd2);
    tbl[17] = mk(1, 0, 1, OP_MVI, D_JUNK, S_IDLE,  O_NONE, 16'd3);

    reset_n = 1'b0; run = 1'b0; mem_ready = 1'b0; opcode = '0;
    {dec_RegWrite, dec_MemWrite, dec_mem_sel, dec_NZ, dec_pc_enable} = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < 18; i++) apply($sformatf("vec%0d", i), tbl[i]);
    mcnt = 16'd3;

    // Timeout in FETCH: 16 un-acked cycles, then sticky FAULT until reset.
    cyc("to_go", 1, 1, 0, OP_ADD, D_ADD, S_IDLE, O_NONE);
    for (int i = 0; i < int'(T); i++)
      cyc($sformatf("to_wait%0d", i), 1, 1, 0, OP_ADD, D_ADD, S_FETCH, O_FETCH);
    cyc("to_fault0", 1, 1, 1, OP_ADD, D_ADD, S_FAULT, O_NONE);
    cyc("to_fault1", 1, 1, 0, OP_ADD, D_ADD, S_FAULT, O_NONE);
    cyc("to_rst", 0, 1, 1, OP_ADD, D_ADD, S_FAULT, O_NONE);
    mcnt = 16'd0;
    cyc("to_cleared", 1, 0, 1, OP_ADD, D_ADD, S_IDLE, O_NONE);

    // Ack on the last allowed wait cycle; run dropped in DECODE still completes.
    cyc("late_go", 1, 1, 0, OP_ADD, D_JUNK, S_IDLE, O_NONE);
    for (int i = 0; i < int'(T) - 1; i++)
      cyc($sformatf("late_wait%0d", i), 1, 1, 0, OP_ADD, D_JUNK, S_FETCH, O_FETCH);
    cyc("late_ack", 1, 1, 1, OP_ADD, D_JUNK, S_FETCH, O_IRL);
    cyc("late_dec", 1, 0, 0, OP_ADD, D_ADD, S_DEC, O_NONE);
    cyc("late_exec", 1, 0, 1, OP_ADD, D_JUNK, S_EXEC, O_NONE);
    cyc("late_wb", 1, 0, 1, OP_ADD, D_JUNK, S_WB, O_RF);
    mcnt = mcnt + 16'd1;
    cyc("late_idle", 1, 0, 1, OP_ADD, D_JUNK, S_IDLE, O_NONE);

    // Count wrap: preload the count register, then retire one pc-only instruction.
    force dut.instr_count_d = 16'hFFFF;
    cyc("wrap_load", 1, 0, 0, OP_ADD, D_JUNK, S_IDLE, O_NONE);
    release dut.instr_count_d;
    mcnt = 16'hFFFF;
    cyc("wrap_go", 1, 1, 0, OP_ADD, D_JUNK, S_IDLE, O_NONE);
    cyc("wrap_fetch", 1, 1, 1, OP_ADD, D_JUNK, S_FETCH, O_IRL);
    cyc("wrap_dec", 1, 1, 1, OP_ADD, 5'b00001, S_DEC, O_NONE);
    cyc("wrap_exec", 1, 1, 1, OP_ADD, D_JUNK, S_EXEC, O_NONE);
    cyc("wrap_wb", 1, 1, 1, OP_ADD, D_JUNK, S_WB, 7'b000_0001);
    mcnt = mcnt + 16'd1;

    // Store instruction, reset lands mid-MEM (with ack present) and wins.
    cyc("mrst_fetch", 1, 1, 1, OP_ADD, D_JUNK, S_FETCH, O_IRL);
    cyc("mrst_dec", 1, 1, 0, 5'b10001, 5'b01000, S_DEC, O_NONE);
    cyc("mrst_wait0", 1, 1, 0, OP_ADD, D_JUNK, S_MEM, O_MEMW);
    cyc("mrst_wait1", 1, 1, 0, OP_ADD, D_JUNK, S_MEM, O_MEMW);
    cyc("mrst_rst", 0, 1, 1, OP_ADD, D_JUNK, S_MEM, O_MEMW);
    mcnt = 16'd0;
    cyc("mrst_idle", 1, 0, 1, OP_ADD, D_JUNK, S_IDLE, O_NONE);

    rand_phase(150);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, meaning consecutive un-acknowledged memory-request cycles before fault (legal range 2..255).
REQ-002 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port run  input  1  enable instruction sequencing.
REQ-005 SHALL have port opcode  input  5  current instruction register opcode.
REQ-006 SHALL have ports dec_RegWrite, dec_MemWrite, dec_mem_sel, dec_NZ, dec_pc_enable  input  1 each  opcode decoder control outputs.
REQ-007 SHALL have port mem_ready  input  1  shared memory port acknowledge.
REQ-008 SHALL have ports mem_req, mem_we, mem_sel  output  1 each  shared memory request, write enable, select (0 instruction, 1 data).
REQ-009 SHALL have ports ir_load, rf_we, nz_we, pc_we  output  1 each  single-cycle strobes to instruction register, register file, NZ flags, PC.
REQ-010 SHALL have ports state  output  3, busy  output  1, fault  output  1, instr_count  output  16.

Function
REQ-011 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=6; state output equals current state encoding.
REQ-012 IDLE: all strobes and mem_req low; busy=0; go FETCH on next edge when run=1.
REQ-013 FETCH: mem_req=1, mem_sel=0, mem_we=0; when mem_ready=1, ir_load=1 in that same cycle and next state DECODE.
REQ-014 DECODE: one cycle; SHALL register opcode and all five dec_* inputs at end of cycle; later changes of those inputs SHALL NOT affect the current instruction.
REQ-015 DECODE next state: MEM if dec_mem_sel=1 or dec_MemWrite=1, else EXEC.
REQ-016 EXEC: one cycle, no strobes, then WB.
REQ-017 MEM: mem_req=1, mem_sel=1, mem_we=latched MemWrite; on mem_ready=1 go WB.
REQ-018 WB: one cycle; rf_we=latched RegWrite, nz_we=latched NZ, pc_we=latched pc_enable; instr_count increments by 1, wrapping 0xFFFF->0x0000.
REQ-019 WB next state: FETCH if run=1, else IDLE; run deassertion in any other state SHALL NOT abort the instruction in flight.
REQ-020 Wait counter (8 bit) SHALL clear on entry to FETCH or MEM and count each cycle there with mem_ready=0.
REQ-021 If wait counter equals MEM_TIMEOUT-1 and mem_ready=0, next state SHALL be FAULT; mem_ready=1 in that same cycle SHALL complete normally.
REQ-022 FAULT: fault=1, all strobes and mem_req low, busy=0; exits only via reset.
REQ-023 mem_ready outside FETCH/MEM SHALL be ignored.
REQ-024 busy=1 in FETCH, DECODE, EXEC, MEM, WB.
REQ-025 Minimum latency with mem_ready held high: 4 cycles per instruction (FETCH, DECODE, EXEC|MEM, WB); each wait cycle adds 1.
REQ-026 At most one of ir_load, rf_we/nz_we/pc_we group active per cycle; each strobe high for exactly one cycle per instruction.

Reset
REQ-027 reset_n=0 at a rising edge SHALL force state IDLE, instr_count=0, fault=0, wait counter=0, latched controls=0, all outputs low, in any state including mid-wait.
REQ-028 After reset_n returns high, sequencing SHALL begin only when run=1.

Verification
REQ-029 run=1, mem_ready=1 constant, opcode 00001 (add: RegWrite=1, NZ=0) -> states 1,2,3,5 repeat, rf_we every 4th cycle, nz_we=0, instr_count +1 per 4 cycles.
REQ-030 opcode 10000 (mvi: mem_sel=1), mem_ready low 3 cycles in MEM -> states 1,2,4,4,4,4,5; mem_sel=1, mem_we=0 during MEM; rf_we pulse in WB.
REQ-031 mem_ready held 0 in FETCH, MEM_TIMEOUT=16 -> FAULT entered after exactly 16 FETCH cycles, fault=1 sticky; reset_n=0 clears to IDLE, fault=0.
REQ-032 mem_ready rises on 16th wait cycle -> no fault, ir_load pulses, DECODE next.
REQ-033 run dropped during DECODE -> instruction completes through WB, then IDLE; instr_count incremented once.
REQ-034 preload instr_count to 0xFFFF via 65535 instructions (or force) -> next WB gives 0x0000; reset_n=0 mid-MEM -> IDLE next cycle, mem_req=0.
